// File: rtl/xbutton_filter.sv
// Push-button conditioner: 2-flop synchroniser, counter debounce,
// and registered level/press/release/auto-repeat outputs.
`ifndef DATA_W
`define DATA_W 20
`endif

module xbutton_filter #(
  parameter logic [`DATA_W-1:0] DEBOUNCE_CYCLES = 20'd100000,
  parameter bit                 REPEAT_EN       = 1'b1,
  parameter logic [`DATA_W-1:0] REPEAT_DELAY    = 20'd500000,
  parameter logic [`DATA_W-1:0] REPEAT_PERIOD   = 20'd150000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int W = `DATA_W;

  localparam logic [W-1:0] DB_LAST  = DEBOUNCE_CYCLES - 1'b1;
  localparam logic [W-1:0] RD_LAST  = REPEAT_DELAY - 1'b1;
  localparam logic [W-1:0] RP_LAST  = REPEAT_PERIOD - 1'b1;
  localparam logic [W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } state_t;

  state_t         state_q;
  logic [W-1:0]   cnt_q;
  logic [W-1:0]   cnt_d;
  logic           s1_q;
  logic           s_q;
  logic           level_q;
  logic           press_q;
  logic           release_q;
  logic           repeat_q;

  // Saturating increment keeps a long hold with repeat disabled from wrapping
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s_q       <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      s1_q      <= btn_in;
      s_q       <= s1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_q) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s_q) begin
            state_q <= IDLE;
          end else if (cnt_q == DB_LAST) begin
            state_q <= HELD;
            level_q <= 1'b1;
            press_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        HELD: begin
          if (!s_q) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end else if (REPEAT_EN && (cnt_q == RD_LAST)) begin
            state_q  <= REPEAT;
            repeat_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        REPEAT: begin
          if (!s_q) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end else if (cnt_q == RP_LAST) begin
            repeat_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back high returns to HELD and restarts the repeat delay
          if (s_q) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= IDLE;
            level_q   <= 1'b0;
            release_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbutton_filter.sv
// Directed bench for xbutton_filter: per-edge expected outputs are queued
// as stimulus is driven and popped after each edge.
module tb_xbutton_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;

  logic lvl_a, prs_a, rel_a, rep_a;
  logic lvl_n, prs_n, rel_n, rep_n;

  int tests = 0;
  int fails = 0;

  logic [3:0] q_a[$];
  logic [3:0] q_n[$];

  always #5 clk = ~clk;

  xbutton_filter #(
    .DEBOUNCE_CYCLES(20'd4),
    .REPEAT_EN      (1'b1),
    .REPEAT_DELAY   (20'd10),
    .REPEAT_PERIOD  (20'd3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn),
    .key_level  (lvl_a),
    .key_press  (prs_a),
    .key_release(rel_a),
    .key_repeat (rep_a)
  );

  xbutton_filter #(
    .DEBOUNCE_CYCLES(20'd4),
    .REPEAT_EN      (1'b0),
    .REPEAT_DELAY   (20'd10),
    .REPEAT_PERIOD  (20'd3)
  ) dut_nr (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn),
    .key_level  (lvl_n),
    .key_press  (prs_n),
    .key_release(rel_n),
    .key_repeat (rep_n)
  );

  function automatic logic [63:0] rng(int lo, int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] b1(int k);
    logic [63:0] m;
    m = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  task automatic chk(string tag, int k);
    logic [3:0] ea, en, oa, on;
    ea = q_a.pop_front();
    en = q_n.pop_front();
    oa = {lvl_a, prs_a, rel_a, rep_a};
    on = {lvl_n, prs_n, rel_n, rep_n};
    tests++;
    assert (oa === ea) else begin
      fails++;
      $error("FAIL %s edge %0d: {lvl,prs,rel,rep} got %b expected %b",
             tag, k, oa, ea);
    end
    tests++;
    assert (on === en) else begin
      fails++;
      $error("FAIL %s_norep edge %0d: {lvl,prs,rel,rep} got %b expected %b",
             tag, k, on, en);
    end
  endtask

  // Two reset edges with a toggling button, then n edges of pattern.
  // Edge 0 is the first edge with rst low.
  task automatic run(string tag, int n,
                     logic [63:0] bp, logic [63:0] rp,
                     logic [63:0] lp, logic [63:0] pp,
                     logic [63:0] ep, logic [63:0] xp);
    for (int k = 0; k < 2; k++) begin
      rst = 1'b1;
      btn = 1'($urandom_range(0, 1));
      q_a.push_back(4'b0000);
      q_n.push_back(4'b0000);
      @(posedge clk);
      #1;
      chk({tag, "_rst"}, k);
    end
    for (int k = 0; k < n; k++) begin
      rst = rp[k];
      btn = bp[k];
      q_a.push_back({lp[k], pp[k], ep[k], xp[k]});
      q_n.push_back({lp[k], pp[k], ep[k], 1'b0});
      @(posedge clk);
      #1;
      chk(tag, k);
    end
  endtask

  initial begin
    #1;
    run("reset_idle", 8, '0, '0, '0, '0, '0, '0);

    run("clean_press", 10, rng(0, 9), '0,
        rng(6, 9), b1(6), '0, '0);

    run("glitch4", 14, rng(0, 3), '0, '0, '0, '0, '0);

    run("pulse5", 16, rng(0, 4), '0,
        rng(6, 10), b1(6), b1(11), '0);

    run("repeat_rel", 38, rng(0, 28), '0,
        rng(6, 34), b1(6), b1(35),
        b1(16) | b1(19) | b1(22) | b1(25) | b1(28));

    run("rel_bounce", 22, rng(0, 7) | rng(10, 12), '0,
        rng(6, 18), b1(6), b1(19), '0);

    run("rep_restart", 27, rng(0, 7) | rng(10, 26), '0,
        rng(6, 26), b1(6), '0, b1(22) | b1(25));

    run("rst_mid", 32, rng(0, 31), rng(20, 21),
        rng(6, 19) | rng(28, 31), b1(6) | b1(28), '0,
        b1(16) | b1(19));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xbutton_filter.md
Name: xbutton_filter

Overview:
- Input-side conditioner for the calculator's push-buttons and keys.
- Synchronises one asynchronous, bouncing button line and rejects glitches with a counter-based stability check.
- Produces a clean key level plus single-cycle press, release and auto-repeat pulses for the keypad/controller logic.
- One instance per key. Memory-mapped peripherals read the pulses as events.

Parameters:
- DEBOUNCE_CYCLES, default 20'd100000: consecutive stable cycles (after the first) required to accept an edge; ≥1.
- REPEAT_EN, default 1: 1 enables auto-repeat while held; 0 disables it.
- REPEAT_DELAY, default 20'd500000: cycles in the held state before the first repeat pulse; ≥1.
- REPEAT_PERIOD, default 20'd150000: cycles between subsequent repeat pulses; ≥1.
- All counts fit in `DATA_W bits. The internal counter is `DATA_W wide.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- btn_in  input  1  raw asynchronous button line, active high
- key_level  output  1  debounced button state
- key_press  output  1  one-cycle pulse on accepted press
- key_release  output  1  one-cycle pulse on accepted release
- key_repeat  output  1  one-cycle auto-repeat pulse

Behaviour:
- Synchronous, active-high reset (rst). On the reset edge:
  - 2-flop synchroniser cleared;
  - state to IDLE, counter to 0;
  - all outputs 0 from the following cycle.
- Reset mid-operation aborts any press or hold. The first outputs after reset need a full re-debounce.
- Synchroniser: btn_in → s1 → s. The FSM uses only s.
- All outputs are registered.
- FSM states and transitions (counter cnt):
  - IDLE: s=1 → PRESS_WAIT, cnt=0.
  - PRESS_WAIT: s=0 → IDLE (glitch rejected, no output). Else if cnt==DEBOUNCE_CYCLES-1 → HELD: key_level←1, key_press pulses, cnt=0. Else cnt++.
  - HELD: s=0 → RELEASE_WAIT, cnt=0. Else if REPEAT_EN and cnt==REPEAT_DELAY-1 → REPEAT: key_repeat pulses, cnt=0. Else cnt++ (saturates if REPEAT_EN=0).
  - REPEAT: s=0 → RELEASE_WAIT, cnt=0. Else if cnt==REPEAT_PERIOD-1: key_repeat pulses, cnt=0. Else cnt++.
  - RELEASE_WAIT: s=1 → HELD, cnt=0 (bounce; repeat delay restarts; no release pulse). Else if cnt==DEBOUNCE_CYCLES-1 → IDLE: key_level←0, key_release pulses. Else cnt++.
- Latency:
  - Press: if btn_in is first sampled high at edge 0 and stays high, key_level and key_press are high after edge DEBOUNCE_CYCLES+2.
  - Release: symmetric; key_level falls and key_release pulses after edge DEBOUNCE_CYCLES+2 counted from the first low sample.
- Minimum accepted pulse: btn_in high (or low) for ≥DEBOUNCE_CYCLES+1 consecutive samples. Shorter runs produce no output.
- Pulse exclusivity:
  - key_press, key_release and key_repeat are never high in the same cycle.
  - Each is high for exactly one cycle per event.
  - No repeat pulse is issued in the cycle the release is detected.
- key_level is constant between key_press and key_release, including across release bounces.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=1.
1. Reset: rst high 2 cycles with btn_in toggling → key_level, key_press, key_release, key_repeat all 0; no pulse within 6 edges after rst drops with btn_in=0.
2. Clean press: btn_in 0→1 at edge 0, held → key_level=1 and key_press=1 after edge 6; key_press=0 after edge 7.
3. Glitch rejection: btn_in high for 4 samples then low → no output ever. High for exactly 5 samples → press accepted after edge 6, then release after the low debounce.
4. Auto-repeat: hold from edge 0 for 30 cycles → key_press after edge 6, then key_repeat after edges 16, 19, 22, 25, 28 (and so on while held). With REPEAT_EN=0 → no key_repeat.
5. Release bounce: while HELD, btn_in low 2 samples, high 3, then low steady → no key_release during the bounce; key_level stays 1; key_release pulses 6 edges after the final steady-low sample; repeat delay restarts after the bounce.
6. Reset mid-hold: rst asserted while in REPEAT → all outputs 0 the next cycle. With btn_in still high after rst drops → a fresh key_press 6 edges later; no key_release is generated.
